// File: rtl/instr_fetch_module_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   req    fetch request strobe, one cycle per fetch (master -> slave)
//   addr   word-aligned fetch address               (master -> slave)
//   rvalid read data valid, one cycle per response  (slave -> master)
//   rdata  instruction word, valid with rvalid      (slave -> master)
interface instr_fetch_module_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_module.sv
// Instruction fetch stage feeding the main decoder.
// Holds the PC, fetches one instruction at a time from a variable-latency
// instruction memory, keeps the word stable until the core commits it, then
// steps to PC+4 or the branch target selected by PCSrc.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   imem         instruction-memory bus (master side)
//   instr_valid  instr/pc hold a fetched, uncommitted instruction
//   instr        current instruction word (instr[6:0] is the decoder op)
//   pc           address of the current instruction
//   instr_ready  core commits the current instruction this cycle
//   PCSrc        take branch target on commit
//   ImmExt       sign-extended branch offset
//   instret      retired-instruction counter (wraps)
//   misalign     sticky misaligned-target flag
//
// Build option FETCH_MISALIGN_TRAP_EN: when defined, a commit to a misaligned
// target loads that target into pc, sets misalign and halts until reset.
// When undefined, the target's low two bits are cleared and fetch continues.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_FETCH | drive imem req for one cycle at pc
// S_WAIT  | waiting for imem rvalid, then latch the instruction
// S_ISSUE | instruction presented, waiting for the core to commit
// S_HALT  | misaligned target trapped; left only by reset
module instr_fetch_module #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  instr_fetch_module_if.master        imem,
  output logic                        instr_valid,
  output logic [31:0]                 instr,
  output logic [31:0]                 pc,
  input  logic                        instr_ready,
  input  logic                        PCSrc,
  input  logic [31:0]                 ImmExt,
  output logic [31:0]                 instret,
  output logic                        misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instret_q, instret_d;
  logic        commit;
  logic [31:0] next_pc;

  assign commit  = instr_valid_q & instr_ready;
  // Modulo-2^32 add; wrap past the top of the address space is intended.
  assign next_pc = pc_q + (PCSrc ? ImmExt : 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      instret_q     <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instret_q     <= instret_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instret_d     = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          instr_d       = imem.rdata;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (commit) begin
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
`else
          pc_d    = next_pc & ~32'd3;
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Gated by rst_n so no request is seen by the memory while reset is held.
  assign imem.req    = rst_n & (state_q == S_FETCH);
  assign imem.addr   = pc_q;

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instret     = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign    = misalign_q;
`else
  assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_module.sv
module tb_instr_fetch_module;
  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] instret;
  logic        misalign;

  int n_chk;
  int n_bad;
  int lat;
  int mem_cnt;
  logic [31:0] mem_addr;

  instr_fetch_module_if imem_if ();

  instr_fetch_module #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_if.master),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready),
    .PCSrc       (PCSrc),
    .ImmExt      (ImmExt),
    .instret     (instret),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // Instruction memory with programmable latency; shares rst_n with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt        <= 0;
      mem_addr       <= 32'd0;
      imem_if.rvalid <= 1'b0;
      imem_if.rdata  <= 32'd0;
    end else begin
      imem_if.rvalid <= 1'b0;
      if (imem_if.req) begin
        mem_addr <= imem_if.addr;
        if (lat <= 1) begin
          imem_if.rvalid <= 1'b1;
          imem_if.rdata  <= mem_word(imem_if.addr);
        end else begin
          mem_cnt <= lat - 1;
        end
      end else if (mem_cnt != 0) begin
        mem_cnt <= mem_cnt - 1;
        if (mem_cnt == 1) begin
          imem_if.rvalid <= 1'b1;
          imem_if.rdata  <= mem_word(mem_addr);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid) break;
      tick();
    end
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  // Commit the current instruction; returns just after the commit edge.
  task automatic commit(input logic src, input logic [31:0] imm);
    instr_ready = 1'b1;
    PCSrc       = src;
    ImmExt      = imm;
    tick();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    ImmExt      = 32'hDEAD_BEEF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk       = 0;
    n_bad       = 0;
    lat         = 1;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    ImmExt      = 32'd0;
    tick();
    tick();

    chk("rst_req",      {31'd0, imem_if.req}, 32'd0);
    chk("rst_pc",       pc, 32'h100);
    chk("rst_instr",    instr, 32'h13);
    chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst_instret",  instret, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("first_req",  {31'd0, imem_if.req}, 32'd1);
    chk("first_addr", imem_if.addr, 32'h100);
    tick();
    chk("wait_req",   {31'd0, imem_if.req}, 32'd0);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_instr", instr, mem_word(32'h100));
    chk("instret0",    instret, 32'd0);

    commit(1'b0, 32'd0);
    chk("seq1_req",     {31'd0, imem_if.req}, 32'd1);
    chk("seq1_addr",    imem_if.addr, 32'h104);
    chk("seq1_instret", instret, 32'd1);
    chk("seq1_valid",   {31'd0, instr_valid}, 32'd0);
    wait_valid(10);
    chk("seq1_instr", instr, mem_word(32'h104));
    commit(1'b0, 32'd0);
    chk("seq2_addr",    imem_if.addr, 32'h108);
    chk("seq2_instret", instret, 32'd2);
    wait_valid(10);
    chk("seq2_instr", instr, mem_word(32'h108));

    commit(1'b1, 32'hFFFF_FFF8);
    chk("br_req",     {31'd0, imem_if.req}, 32'd1);
    chk("br_addr",    imem_if.addr, 32'h100);
    chk("br_instret", instret, 32'd3);
    wait_valid(10);

    // Long memory latency with instr_ready held high throughout.
    lat         = 5;
    instr_ready = 1'b1;
    tick();
    chk("lat_addr",    imem_if.addr, 32'h104);
    chk("lat_instret", instret, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lat_hold_valid", {31'd0, instr_valid}, 32'd0);
      chk("lat_hold_pc",    pc, 32'h104);
    end
    tick();
    chk("lat_valid",   {31'd0, instr_valid}, 32'd1);
    chk("lat_instr",   instr, mem_word(32'h104));
    chk("lat_instret", instret, 32'd4);
    tick();
    instr_ready = 1'b0;
    chk("lat_once_instret", instret, 32'd5);
    chk("lat_once_pc",      pc, 32'h108);
    wait_valid(20);
    chk("lat2_instr", instr, mem_word(32'h108));

    // Reset during WAIT.
    commit(1'b0, 32'd0);
    chk("mid_pc", pc, 32'h10C);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",      pc, 32'h100);
    chk("arst_valid",   {31'd0, instr_valid}, 32'd0);
    chk("arst_instret", instret, 32'd0);
    chk("arst_req",     {31'd0, imem_if.req}, 32'd0);
    tick();
    lat   = 1;
    rst_n = 1'b1;
    #1;
    chk("rerst_req",  {31'd0, imem_if.req}, 32'd1);
    chk("rerst_addr", imem_if.addr, 32'h100);
    wait_valid(10);
    chk("rerst_instr", instr, mem_word(32'h100));

    // Wrap across the top of the address space.
    commit(1'b1, 32'hFFFF_FEFC);
    chk("top_addr", imem_if.addr, 32'hFFFF_FFFC);
    wait_valid(10);
    commit(1'b0, 32'd0);
    chk("wrap_addr",    imem_if.addr, 32'h0);
    chk("wrap_instret", instret, 32'd2);
    wait_valid(10);
    commit(1'b1, 32'h100);
    chk("back_addr", imem_if.addr, 32'h100);
    wait_valid(10);

    commit(1'b1, 32'd2);
    chk("mis_instret", instret, 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_pc",   pc, 32'h102);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("mis_req",   {31'd0, imem_if.req}, 32'd0);
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    instr_ready = 1'b0;
    chk("mis_pc_hold",   pc, 32'h102);
    chk("mis_instret_h", instret, 32'd4);
`else
    chk("mis_flag", {31'd0, misalign}, 32'd0);
    chk("mis_req",  {31'd0, imem_if.req}, 32'd1);
    chk("mis_addr", imem_if.addr, 32'h100);
    wait_valid(10);
    chk("mis_instr", instr, mem_word(32'h100));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
